mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_pkg.sv | 14 +
 rtl/rr_pick2.sv | 16 +
 rtl/mul_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and default sizing for the multiply arbiter slice.
package mul_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_MUL_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic grant_id,
  output logic grant_valid
);

  // A lone request always wins; only a tie consults the pointer.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = (req0 & req1) ? ~last_id : req1;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto one external multi-cycle Booth multiplier.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0,
  input  logic                      req1,
  input  logic signed [WIDTH-1:0]   x0,
  input  logic signed [WIDTH-1:0]   y0,
  input  logic signed [WIDTH-1:0]   x1,
  input  logic signed [WIDTH-1:0]   y1,
  output logic                      done0,
  output logic                      done1,
  output logic signed [2*WIDTH-1:0] res,
  output logic                      busy,
  output logic signed [WIDTH-1:0]   m_x,
  output logic signed [WIDTH-1:0]   m_y,
  output logic                      m_load,
  input  logic signed [2*WIDTH-1:0] m_z
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt;
  logic          gid;
  logic          last_id;
  logic          grant_id;
  logic          grant_valid;
  logic          last_run;

  rr_pick2 u_pick (
    .req0        (req0),
    .req1        (req1),
    .last_id     (last_id),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign last_run = (cnt == CW'(MUL_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_d = state_q;
    m_load  = 1'b0;
    busy    = 1'b1;
    done0   = 1'b0;
    done1   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (grant_valid) state_d = LOAD;
      end
      LOAD: begin
        m_load  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (last_run) state_d = DONE;
      end
      DONE: begin
        done0   = ~gid;
        done1   = gid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, run counter, result capture and round-robin pointer.
  // The product is captured on the edge that enters DONE, so res is already
  // valid while the done pulse is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      gid     <= 1'b0;
      last_id <= 1'b1;
      m_x     <= '0;
      m_y     <= '0;
      res     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            gid <= grant_id;
            m_x <= grant_id ? x1 : x0;
            m_y <= grant_id ? y1 : y0;
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_run) begin
            res     <= m_z;
            last_id <= gid;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
